// File: rtl/regfile_sb_if.sv
// Operand-read, writeback and issue signals of the decode-stage register file.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              a_busy;
    logic              b_busy;
    logic              any_busy;

    modport master (
        output rs, rt, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  A, B, a_busy, b_busy, any_busy
    );

    modport slave (
        input  rs, rt, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output A, B, a_busy, b_busy, any_busy
    );
endinterface

// File: rtl/regfile_sb.sv
// 2-read/1-write register file with write-to-read bypass and a per-register busy
// scoreboard; reads may be combinational or registered.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int READ_REG = 0
) (
    input  logic        clk,
    input  logic        rst,
    regfile_sb_if.slave bus
);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic              wr_ok;
    logic              iss_ok;
    logic [DATA_W-1:0] rv_a;
    logic [DATA_W-1:0] rv_b;
    logic              bv_a;
    logic              bv_b;

    function automatic logic writable(input logic [ADDR_W-1:0] x);
        return (int'(x) < DEPTH) && !((ZERO_REG != 0) && (x == '0));
    endfunction

    assign wr_ok  = bus.wr_en  && writable(bus.wr_addr);
    assign iss_ok = bus.iss_en && writable(bus.iss_addr);

    // NOTE: the register array is reset explicitly because a flush must return every
    // architectural register to zero; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: non-blocking assignments give last-assignment-wins semantics, so
                // the issue below overrides a same-address writeback clear.
                if (wr_ok && bus.wr_addr == ADDR_W'(i)) begin
                    regs[i] <= bus.wr_data;
                    busy[i] <= 1'b0;
                end
                if (iss_ok && bus.iss_addr == ADDR_W'(i)) begin
                    busy[i] <= 1'b1;
                end
            end
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        rv_a = '0;
        rv_b = '0;
        bv_a = 1'b0;
        bv_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.rs == ADDR_W'(i)) begin
                rv_a = regs[i];
                bv_a = busy[i];
            end
            if (bus.rt == ADDR_W'(i)) begin
                rv_b = regs[i];
                bv_b = busy[i];
            end
        end

        // A same-cycle writeback is forwarded; its busy clear is forwarded only if no
        // newer producer issues to the same register in that cycle.
        if (!writable(bus.rs)) begin
            rv_a = '0;
            bv_a = 1'b0;
        end else if (bus.wr_en && bus.wr_addr == bus.rs) begin
            rv_a = bus.wr_data;
            if (!(bus.iss_en && bus.iss_addr == bus.rs)) begin
                bv_a = 1'b0;
            end
        end

        if (!writable(bus.rt)) begin
            rv_b = '0;
            bv_b = 1'b0;
        end else if (bus.wr_en && bus.wr_addr == bus.rt) begin
            rv_b = bus.wr_data;
            if (!(bus.iss_en && bus.iss_addr == bus.rt)) begin
                bv_b = 1'b0;
            end
        end
    end

    generate
        if (READ_REG != 0) begin : g_read_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    bus.A      <= '0;
                    bus.B      <= '0;
                    bus.a_busy <= 1'b0;
                    bus.b_busy <= 1'b0;
                end else begin
                    bus.A      <= rv_a;
                    bus.B      <= rv_b;
                    bus.a_busy <= bv_a;
                    bus.b_busy <= bv_b;
                end
            end
        end else begin : g_read_comb
            assign bus.A      = rv_a;
            assign bus.B      = rv_b;
            assign bus.a_busy = bv_a;
            assign bus.b_busy = bv_b;
        end
    endgenerate

    assign bus.any_busy = |busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Drives a combinational-read and a registered-read instance (DEPTH=16) with identical
// stimulus and checks both against a reference model plus a one-deep result queue.
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DP = 16;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          ab;
        logic          bb;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [AW-1:0] rs, rt, wr_addr, iss_addr;
    logic          wr_en, iss_en;
    logic [DW-1:0] wr_data;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mreg [DP];
    logic [DP-1:0] mbusy;
    exp_t          sb [$];

    always #5 clk = ~clk;

    regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
    regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

    assign if0.rs = rs;           assign if1.rs = rs;
    assign if0.rt = rt;           assign if1.rt = rt;
    assign if0.wr_en = wr_en;     assign if1.wr_en = wr_en;
    assign if0.wr_addr = wr_addr; assign if1.wr_addr = wr_addr;
    assign if0.wr_data = wr_data; assign if1.wr_data = wr_data;
    assign if0.iss_en = iss_en;   assign if1.iss_en = iss_en;
    assign if0.iss_addr = iss_addr; assign if1.iss_addr = iss_addr;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .ZERO_REG(1), .READ_REG(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .ZERO_REG(1), .READ_REG(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    function automatic bit wrt(input logic [AW-1:0] x);
        return (x < AW'(DP)) && (x != '0);
    endfunction

    function automatic logic [DW-1:0] rv(input logic [AW-1:0] x);
        if (!wrt(x)) return '0;
        if (wr_en && wr_addr == x) return wr_data;
        return mreg[x[3:0]];
    endfunction

    function automatic logic bv(input logic [AW-1:0] x);
        if (!wrt(x)) return 1'b0;
        if (wr_en && wr_addr == x && !(iss_en && iss_addr == x)) return 1'b0;
        return mbusy[x[3:0]];
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic ie, input logic [AW-1:0] ia,
                         input logic [AW-1:0] a, input logic [AW-1:0] b);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
        iss_en = ie; iss_addr = ia; rs = a; rt = b;
    endtask

    // One clock: check combinational outputs mid-cycle, queue the registered
    // expectation, advance the model at the edge, then retire the queue entry.
    task automatic step(input string tag);
        exp_t e;
        exp_t got;
        @(negedge clk);
        check($sformatf("%s comb A", tag),      if0.A, rv(rs));
        check($sformatf("%s comb B", tag),      if0.B, rv(rt));
        check($sformatf("%s comb a_busy", tag), DW'(if0.a_busy), DW'(bv(rs)));
        check($sformatf("%s comb b_busy", tag), DW'(if0.b_busy), DW'(bv(rt)));
        check($sformatf("%s any_busy0", tag),   DW'(if0.any_busy), DW'(|mbusy));
        check($sformatf("%s any_busy1", tag),   DW'(if1.any_busy), DW'(|mbusy));
        if (rst) e = '0;
        else     e = '{a: rv(rs), b: rv(rt), ab: bv(rs), bb: bv(rt)};
        sb.push_back(e);

        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DP; i++) mreg[i] = '0;
            mbusy = '0;
        end else begin
            if (wr_en && wrt(wr_addr)) begin
                mreg[wr_addr[3:0]]  = wr_data;
                mbusy[wr_addr[3:0]] = 1'b0;
            end
            if (iss_en && wrt(iss_addr)) mbusy[iss_addr[3:0]] = 1'b1;
        end

        #1;
        check($sformatf("%s queue depth", tag), DW'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
            got = sb.pop_front();
            check($sformatf("%s reg A", tag),      if1.A, got.a);
            check($sformatf("%s reg B", tag),      if1.B, got.b);
            check($sformatf("%s reg a_busy", tag), DW'(if1.a_busy), DW'(got.ab));
            check($sformatf("%s reg b_busy", tag), DW'(if1.b_busy), DW'(got.bb));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DP; i++) mreg[i] = '0;
        mbusy = '0;
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        @(posedge clk);
        #1;
        step("reset");

        // Every address, implemented or not, reads zero and idle after reset.
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b0, '0, AW'(i), AW'(31 - i));
            step($sformatf("rd_after_reset %0d", i));
        end

        drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 5'd0, 5'd0);  step("wr r5");
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd5, 5'd0);              step("rd r5");
        drive(1'b0, 1'b1, 5'd0, 32'h00001234, 1'b0, '0, 5'd0, 5'd5);  step("wr r0");
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd0);              step("rd r0");

        drive(1'b0, 1'b1, 5'd7, 32'h00000055, 1'b0, '0, 5'd7, 5'd7);  step("bypass r7");
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd7, 5'd5);              step("rd r7");

        drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd9);            step("iss r9");
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd7);              step("busy r9");
        drive(1'b0, 1'b1, 5'd9, 32'h00000042, 1'b0, '0, 5'd9, 5'd9);  step("wb r9");
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd9);              step("idle r9");

        drive(1'b0, 1'b1, 5'd3, 32'h00000077, 1'b1, 5'd3, 5'd3, 5'd3); step("iss+wr r3");
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd9);               step("busy r3");
        drive(1'b0, 1'b1, 5'd12, 32'hCAFE0000, 1'b1, 5'd11, 5'd11, 5'd12); step("iss r11 wr r12");
        drive(1'b0, 1'b1, 5'd3, 32'h00000078, 1'b0, '0, 5'd3, 5'd11);  step("wb r3");

        drive(1'b0, 1'b1, 5'd20, 32'h0000ABCD, 1'b1, 5'd20, 5'd20, 5'd16); step("wr r20");
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd20, 5'd16);                 step("rd r20");
        drive(1'b0, 1'b1, 5'd15, 32'h0F0F0F0F, 1'b1, 5'd0, 5'd15, 5'd0);   step("wr r15");
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd15, 5'd15);                 step("rd r15");

        drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd4, 5'd4, 5'd5);            step("iss r4");
        drive(1'b1, 1'b1, 5'd6, 32'h11111111, 1'b1, 5'd8, 5'd4, 5'd6); step("reset mid");
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd4, 5'd5);              step("post reset a");
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd6, 5'd8);              step("post reset b");

        for (int n = 0; n < 150; n++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                  AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
            step($sformatf("rand %0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
